// File: rtl/msi_gen_pkg.sv
// Shared SoC constants for the IMSIC message path.
// Also holds the MSI generator state encoding and its address helper.
package msi_gen_pkg;

  localparam logic [63:0] IMSICBase         = 64'h0000_0000_2400_0000;
  localparam logic [63:0] IMSICLength       = 64'h0000_0000_0000_4000;
  localparam logic [63:0] SeteipnumLeOffset = 64'h0000_0000_0000_0000;

  typedef enum logic [1:0] {
    MSI_IDLE      = 2'd0,
    MSI_ADDR_DATA = 2'd1,
    MSI_RESP      = 2'd2
  } msi_state_e;

  localparam logic [1:0] ST_IDLE      = MSI_IDLE;
  localparam logic [1:0] ST_ADDR_DATA = MSI_ADDR_DATA;
  localparam logic [1:0] ST_RESP      = MSI_RESP;

  // Doorbell address of one interrupt file: page base plus the little-endian seteipnum register.
  function automatic logic [63:0] msi_target_addr(input logic [63:0] base,
                                                  input logic [63:0] stride,
                                                  input logic [63:0] file);
    return base + SeteipnumLeOffset + (file * stride);
  endfunction

endpackage

// File: rtl/msi_gen_if.sv
// Write-only AXI-style channel bundle (AW, W, B) that carries MSI doorbell writes.
interface msi_gen_if;

  logic        aw_valid;
  logic        aw_ready;
  logic [63:0] aw_addr;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_resp;

  modport master (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    input  aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    output aw_ready, w_ready, b_valid, b_resp
  );

endinterface

// File: rtl/msi_fifo.sv
// Power-of-two request queue; a push into a full queue is taken when a pop happens in the same cycle.
module msi_fifo #(
  parameter int Depth = 4,
  parameter int Width = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int              PtrW  = $clog2(Depth);
  localparam logic [PtrW:0]   Level = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_r [Depth];
  logic [PtrW-1:0]  wr_ptr_r;
  logic [PtrW-1:0]  rd_ptr_r;
  logic [PtrW:0]    count_r;
  logic             push_en_s;
  logic             pop_en_s;

  assign empty     = (count_r == {(PtrW + 1){1'b0}});
  assign full      = (count_r == Level);
  assign pop_en_s  = pop && !empty;
  assign push_en_s = push && (!full || pop_en_s);
  assign dout      = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      count_r  <= {(PtrW + 1){1'b0}};
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PtrW - 1){1'b0}}, 1'b1};
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PtrW - 1){1'b0}}, 1'b1};
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_r <= count_r + {{PtrW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{PtrW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are only observed while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/msi_gen.sv
// MSI generator: queues (file, EIID) requests and turns each one into a single
// 32-bit doorbell write to the IMSIC seteipnum_le register of the chosen file.
module msi_gen
  import msi_gen_pkg::*;
#(
  parameter int          NrIntpFiles = 3,
  parameter logic [63:0] ImsicBase   = IMSICBase,
  parameter logic [63:0] FileStride  = 64'h0000_0000_0000_1000,
  parameter int          FifoDepth   = 4,
  parameter int          EiidWidth   = 11,
  localparam int         FileW       = (NrIntpFiles > 1) ? $clog2(NrIntpFiles) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [FileW-1:0]     req_file_i,
  input  logic [EiidWidth-1:0] req_eiid_i,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [63:0]          aw_addr_o,
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
  output logic [31:0]          w_data_o,
  output logic [3:0]           w_strb_o,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic [1:0]           b_resp_i,
  output logic                 drop_o,
  output logic                 err_o,
  output logic                 busy_o
);

  localparam int EntryW = FileW + EiidWidth;

  logic [1:0]           state_r;
  logic                 aw_valid_r;
  logic                 w_valid_r;
  logic                 b_ready_r;
  logic                 drop_r;
  logic                 err_r;
  logic [63:0]          aw_addr_r;
  logic [31:0]          w_data_r;
  logic [3:0]           w_strb_r;

  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 fifo_push_s;
  logic                 fifo_pop_s;
  logic [EntryW-1:0]    fifo_head_s;
  logic [FileW-1:0]     head_file_s;
  logic [EiidWidth-1:0] head_eiid_s;
  logic                 req_accept_s;
  logic                 req_bad_s;
  logic                 aw_done_s;
  logic                 w_done_s;

  assign req_ready_o  = !fifo_full_s && !rst_i;
  assign req_accept_s = req_valid_i && req_ready_o;
  // Identity 0 is reserved by the IMSIC and files beyond the implemented set have no page.
  assign req_bad_s    = (req_eiid_i == {EiidWidth{1'b0}}) ||
                        (32'(req_file_i) >= 32'(NrIntpFiles));
  assign fifo_push_s  = req_accept_s && !req_bad_s;
  assign fifo_pop_s   = (state_r == ST_IDLE) && !fifo_empty_s;

  assign head_file_s  = fifo_head_s[EntryW-1:EiidWidth];
  assign head_eiid_s  = fifo_head_s[EiidWidth-1:0];

  // A channel counts as done once its valid has dropped or it handshakes this cycle.
  assign aw_done_s    = !aw_valid_r || aw_ready_i;
  assign w_done_s     = !w_valid_r || w_ready_i;

  msi_fifo #(
    .Depth (FifoDepth),
    .Width (EntryW)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (fifo_push_s),
    .din   ({req_file_i, req_eiid_i}),
    .pop   (fifo_pop_s),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Transaction FSM, output payload registers and the one-cycle status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      aw_valid_r <= 1'b0;
      w_valid_r  <= 1'b0;
      b_ready_r  <= 1'b0;
      drop_r     <= 1'b0;
      err_r      <= 1'b0;
      aw_addr_r  <= 64'h0;
      w_data_r   <= 32'h0;
      w_strb_r   <= 4'h0;
    end else begin
      drop_r <= req_accept_s && req_bad_s;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            aw_addr_r  <= msi_target_addr(ImsicBase, FileStride, 64'(head_file_s));
            w_data_r   <= 32'(head_eiid_s);
            w_strb_r   <= 4'hF;
            aw_valid_r <= 1'b1;
            w_valid_r  <= 1'b1;
            state_r    <= ST_ADDR_DATA;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_ADDR_DATA: begin
          if (aw_ready_i) begin
            aw_valid_r <= 1'b0;
          end
          if (w_ready_i) begin
            w_valid_r <= 1'b0;
          end
          if (aw_done_s && w_done_s) begin
            b_ready_r <= 1'b1;
            state_r   <= ST_RESP;
          end else begin
            state_r   <= ST_ADDR_DATA;
          end
        end
        ST_RESP: begin
          if (b_valid_i) begin
            b_ready_r <= 1'b0;
            err_r     <= (b_resp_i != 2'b00);
            state_r   <= ST_IDLE;
          end else begin
            state_r   <= ST_RESP;
          end
        end
        default: begin
          aw_valid_r <= 1'b0;
          w_valid_r  <= 1'b0;
          b_ready_r  <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  // Control outputs are forced low for the whole reset cycle, not just after the edge.
  assign aw_valid_o = aw_valid_r && !rst_i;
  assign w_valid_o  = w_valid_r && !rst_i;
  assign b_ready_o  = b_ready_r && !rst_i;
  assign drop_o     = drop_r && !rst_i;
  assign err_o      = err_r && !rst_i;
  assign busy_o     = (!fifo_empty_s || (state_r != ST_IDLE)) && !rst_i;
  assign aw_addr_o  = aw_addr_r;
  assign w_data_o   = w_data_r;
  assign w_strb_o   = w_strb_r;

endmodule
